line_window_feeder: RTL and testbench

LINE_WINDOW_FEEDER -- requirements
Module: line_window_feeder

---
 rtl/line_window_feeder.sv | 134 +++++++++++++
 tb/tb_line_window_feeder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/line_window_feeder.sv
// Raster-to-3-row column feeder: two line stores build vertical pixel
// triples (rows r-2, r-1, r) with a valid/ready output register stage.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_pixel/in_sof
// raster input; out_valid/out_ready, pix_top/pix_mid/pix_bot, out_eol
// column-triple output. Optional LWF_FRAME_STATS_EN adds frame_done
// (1-cycle pulse after a frame's last pixel) and frame_count (16-bit).
module line_window_feeder #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_pixel,
    input  logic                   in_sof,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_WIDTH-1:0] pix_top,
    output logic [PIXEL_WIDTH-1:0] pix_mid,
    output logic [PIXEL_WIDTH-1:0] pix_bot,
    output logic                   out_eol
`ifdef LWF_FRAME_STATS_EN
    ,
    output logic                   frame_done,
    output logic [15:0]            frame_count
`endif
);

    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    localparam logic [0:0] FILL   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]            state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [CW-1:0]         pos_c;
    logic [RW-1:0]         pos_r;
    logic [CW-1:0]         col_nxt;
    logic [RW-1:0]         row_nxt;
    logic                  acc;
    logic                  eol_in;
    logic                  last_px;
    logic                  go_stream;
    logic                  emit;

    logic [PIXEL_WIDTH-1:0] l0 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] l1 [IMG_WIDTH];

    // FILL never produces output, so it never needs to stall.
    assign in_ready = (state == FILL) | out_ready | ~out_valid;

    // in_sof re-labels the current pixel as (0,0) before any decode.
    always_comb begin
        acc       = in_valid & in_ready;
        pos_c     = in_sof ? '0 : col;
        pos_r     = in_sof ? '0 : row;
        eol_in    = (pos_c == COL_LAST);
        last_px   = eol_in && (pos_r == ROW_LAST);
        go_stream = (state == FILL) && (pos_r == ROW_ONE) && eol_in;
        emit      = acc && (state == STREAM) && !in_sof;
        col_nxt   = eol_in ? '0 : pos_c + 1'b1;
        row_nxt   = pos_r;
        if (eol_in) begin
            row_nxt = (pos_r == ROW_LAST) ? '0 : pos_r + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            col   <= '0;
            row   <= '0;
        end else if (acc) begin
            col <= col_nxt;
            row <= row_nxt;
            if (in_sof) begin
                state <= FILL;
            end else if (go_stream) begin
                state <= STREAM;
            end else if (state == STREAM && last_px) begin
                state <= FILL;
            end
        end
    end

    // Line stores carry no reset; stale contents are overwritten before use.
    always_ff @(posedge clk) begin
        if (acc) begin
            l1[pos_c] <= l0[pos_c];
            l0[pos_c] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
            pix_top   <= '0;
            pix_mid   <= '0;
            pix_bot   <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_eol   <= eol_in;
            pix_top   <= l1[pos_c];
            pix_mid   <= l0[pos_c];
            pix_bot   <= in_pixel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LWF_FRAME_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= acc && last_px;
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_window_feeder.sv
// Directed bench for line_window_feeder at 4x4, pixel = 16*row+col.
// Covers streaming, backpressure, resync, reset and optional frame stats.
module tb_line_window_feeder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixel;
    logic       in_sof;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pix_top;
    logic [7:0] pix_mid;
    logic [7:0] pix_bot;
    logic       out_eol;
`ifdef LWF_FRAME_STATS_EN
    logic       frame_done;
    logic [15:0] frame_count;
`endif

    int tests;
    int fails;

    line_window_feeder #(
        .PIXEL_WIDTH(8),
        .IMG_WIDTH(4),
        .IMG_HEIGHT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pixel(in_pixel),
        .in_sof(in_sof),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .pix_top(pix_top),
        .pix_mid(pix_mid),
        .pix_bot(pix_bot),
        .out_eol(out_eol)
`ifdef LWF_FRAME_STATS_EN
        ,
        .frame_done(frame_done),
        .frame_count(frame_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_triple(input string tag, input logic [7:0] t,
                              input logic [7:0] m, input logic [7:0] b,
                              input logic e);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_top"}, 32'(pix_top), 32'(t));
        chk({tag, "_mid"}, 32'(pix_mid), 32'(m));
        chk({tag, "_bot"}, 32'(pix_bot), 32'(b));
        chk({tag, "_eol"}, 32'(out_eol), 32'(e));
    endtask

    // Drive one pixel; returns #1 after the edge that accepted it.
    task automatic push(input logic [7:0] p, input logic sof);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_pixel = p;
        in_sof   = sof;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("push_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic full_frame();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] p;
                p = 8'(16 * r + c);
                push(p, 1'b0);
                if (r < 2) begin
                    chk("fill_quiet", 32'(out_valid), 32'd0);
                end else begin
                    chk_triple("stream", 8'(16 * (r - 2) + c),
                               8'(16 * (r - 1) + c), p, (c == 3));
                end
`ifdef LWF_FRAME_STATS_EN
                chk("frame_done", 32'(frame_done), 32'((r == 3) && (c == 3)));
`endif
            end
        end
    endtask

    initial begin
        logic [7:0] tail [7];
        logic [7:0] rs [7];
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = 8'h00;
        in_sof    = 1'b0;
        out_ready = 1'b1;

        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_eol", 32'(out_eol), 32'd0);
        chk("rst_top", 32'(pix_top), 32'd0);
        chk("rst_mid", 32'(pix_mid), 32'd0);
        chk("rst_bot", 32'(pix_bot), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
`ifdef LWF_FRAME_STATS_EN
        chk("rst_count", 32'(frame_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous frame
        full_frame();
        @(posedge clk);
        #1;
        chk("idle_clear", 32'(out_valid), 32'd0);

        // Backpressure
        for (int k = 0; k < 8; k++) begin
            push(8'(16 * (k / 4) + (k % 4)), 1'b0);
            chk("bp_fill", 32'(out_valid), 32'd0);
        end
        push(8'h20, 1'b0);
        chk_triple("bp_first", 8'h00, 8'h10, 8'h20, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = 8'h21;
        in_sof    = 1'b0;
        repeat (3) begin
            #1;
            chk("bp_stall", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk_triple("bp_hold", 8'h00, 8'h10, 8'h20, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_triple("bp_next", 8'h01, 8'h11, 8'h21, 1'b0);
        tail = '{8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33, 8'h00};
        for (int k = 0; k < 6; k++) push(tail[k], 1'b0);
        chk_triple("bp_last", 8'h13, 8'h23, 8'h33, 1'b1);

        // Resync at (row 2, col 1)
        for (int k = 0; k < 8; k++) push(8'(16 * (k / 4) + (k % 4)), 1'b0);
        push(8'h20, 1'b0);
        chk_triple("rs_pre", 8'h00, 8'h10, 8'h20, 1'b0);
        push(8'h00, 1'b1);
        chk("rs_sof_quiet", 32'(out_valid), 32'd0);
        rs = '{8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13};
        for (int k = 0; k < 7; k++) begin
            push(rs[k], 1'b0);
            chk("rs_fill", 32'(out_valid), 32'd0);
        end
        push(8'h20, 1'b0);
        chk_triple("rs_first", 8'h00, 8'h10, 8'h20, 1'b0);
        tail = '{8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33};
        for (int k = 0; k < 7; k++) push(tail[k], 1'b0);
        chk_triple("rs_last", 8'h13, 8'h23, 8'h33, 1'b1);

        // Mid-frame reset after 10th pixel
        for (int k = 0; k < 8; k++) push(8'(16 * (k / 4) + (k % 4)), 1'b0);
        push(8'h20, 1'b0);
        push(8'h21, 1'b0);
        chk_triple("mr_pre", 8'h01, 8'h11, 8'h21, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_eol", 32'(out_eol), 32'd0);
        chk("mr_top", 32'(pix_top), 32'd0);
        chk("mr_mid", 32'(pix_mid), 32'd0);
        chk("mr_bot", 32'(pix_bot), 32'd0);
        chk("mr_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        full_frame();

        // Second back-to-back frame
        full_frame();
`ifdef LWF_FRAME_STATS_EN
        @(posedge clk);
        #1;
        chk("frame_count", 32'(frame_count), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
